// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and line levels, used by the
// transmitter and the future receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable bit-period counter: counts 0..div_eff-1 and flags the last cycle
// of each bit period. A divisor of 0 behaves as 1.
module uart_baud_cnt #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             bit_end
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] div_eff;

  assign div_eff = (div == '0) ? DIV_W'(1) : div;
  assign bit_end = (cnt_q == (div_eff - DIV_W'(1)));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (load || bit_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, DATA_W data bits LSB first, optional
// parity (macro UART_TX_PARITY_EN), STOP_BITS stop bits, programmable bit time.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DIV_W     = 16,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic              parity_odd,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              Tx_Serial,
  output logic              Tx_Active,
  output logic              tx_done
);

  localparam int BIT_CNT_W = $clog2(DATA_W);

  uart_state_e          state_q, state_d;
  logic [DATA_W-1:0]    shift_q, shift_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 serial_d, active_d, done_d;
  logic                 accept, bit_end;

`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  assign tx_ready = (state_q == IDLE);
  assign accept   = tx_valid & tx_ready;

  uart_baud_cnt #(.DIV_W(DIV_W)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .div     (div_q),
    .bit_end (bit_end)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    serial_d   = Tx_Serial;
    active_d   = Tx_Active;
    done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      IDLE: begin
        serial_d = LINE_IDLE;
        active_d = 1'b0;
        if (tx_valid) begin
          state_d    = START;
          shift_d    = tx_data;
          div_d      = clk_div;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          serial_d   = LINE_START;
          active_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
          // The shift register is consumed during DATA, so fold parity now.
          parity_d   = (^tx_data) ^ parity_odd;
`endif
        end
      end

      START: begin
        if (bit_end) begin
          state_d  = DATA;
          serial_d = shift_q[0];
          shift_d  = shift_q >> 1;
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == BIT_CNT_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d    = PARITY;
            serial_d   = parity_q;
`else
            state_d    = STOP;
            serial_d   = LINE_IDLE;
            stop_cnt_d = 1'b0;
`endif
          end else begin
            serial_d  = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d    = STOP;
          serial_d   = LINE_IDLE;
          stop_cnt_d = 1'b0;
        end
      end
`endif

      STOP: begin
        serial_d = LINE_IDLE;
        if (bit_end) begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            state_d  = IDLE;
            active_d = 1'b0;
            done_d   = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end

      default: begin
        state_d  = IDLE;
        serial_d = LINE_IDLE;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      Tx_Serial  <= LINE_IDLE;
      Tx_Active  <= 1'b0;
      tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      Tx_Serial  <= serial_d;
      Tx_Active  <= active_d;
      tx_done    <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: two configurations (8N1 and 7-bit with
// two stop bits), directed and random words, cycle-exact line model.
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int DW = (g == 0) ? 8 : 7;
    localparam int SB = (g == 0) ? 1 : 2;
    localparam int NB = 1 + DW + P + SB;

    logic          rst = 1'b1;
    logic          tx_valid = 1'b0;
    logic          parity_odd = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic [15:0]   clk_div = 16'd1;
    logic          tx_ready, tx_serial, tx_active, tx_done;
    bit            fin = 1'b0;

    logic [8:0] q_data[$];
    int         q_div[$];
    logic       q_odd[$];

    uart_tx_frame #(.DATA_W(DW), .DIV_W(16), .STOP_BITS(SB)) dut (
      .clk        (clk),
      .rst        (rst),
      .clk_div    (clk_div),
      .parity_odd (parity_odd),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .Tx_Serial  (tx_serial),
      .Tx_Active  (tx_active),
      .tx_done    (tx_done)
    );

    // Frame bit k: start 0, data LSB first, optional parity, then stop 1s.
    function automatic logic exp_bit(input logic [8:0] d, input logic odd, input int k);
      if (k == 0) return 1'b0;
      if (k <= DW) return d[k-1];
      if (P == 1 && k == DW + 1) return (^d) ^ odd;
      return 1'b1;
    endfunction

    task automatic present(input logic [8:0] d, input int dv, input logic odd);
      tx_data    = d[DW-1:0];
      clk_div    = 16'(dv);
      parity_odd = odd;
      tx_valid   = 1'b1;
      q_data.push_back(9'(tx_data));
      q_div.push_back((dv == 0) ? 1 : dv);
      q_odd.push_back(odd);
    endtask

    task automatic wait_accept();
      int t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!tx_ready && t < 3000);
      check($sformatf("i%0d accept", g), 32'(tx_ready), 32'd1);
      @(posedge clk);
      #1;
    endtask

    task automatic idle_gap(input int n);
      tx_valid = 1'b0;
      repeat (n) begin
        tx_data    = DW'($urandom);
        clk_div    = 16'($urandom);
        parity_odd = 1'($urandom);
        @(posedge clk);
        #1;
      end
    endtask

    task automatic reset_test();
      present(9'h0C3, 3, 1'b0);
      wait_accept();
      tx_valid = 1'b0;
      repeat (11) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check($sformatf("i%0d async reset {ser,act,done,rdy}", g),
            32'({tx_serial, tx_active, tx_done, tx_ready}), 32'b1001);
      @(posedge clk);
      #1;
      check($sformatf("i%0d reset held {ser,act,done,rdy}", g),
            32'({tx_serial, tx_active, tx_done, tx_ready}), 32'b1001);
      rst = 1'b1;
      idle_gap(5);
    endtask

    task automatic run_frame();
      logic [8:0] d;
      int         dv;
      logic       odd;
      if (q_data.size() == 0) begin
        check($sformatf("i%0d accept without offer", g), 32'd1, 32'd0);
        @(negedge clk);
        return;
      end
      d   = q_data.pop_front();
      dv  = q_div.pop_front();
      odd = q_odd.pop_front();
      for (int k = 0; k < NB; k++) begin
        for (int c = 0; c < dv; c++) begin
          @(negedge clk);
          if (!rst) return;
          check($sformatf("i%0d data %0h bit%0d", g, d, k), 32'(tx_serial), 32'(exp_bit(d, odd, k)));
          check($sformatf("i%0d in-frame {act,done,rdy}", g),
                32'({tx_active, tx_done, tx_ready}), 32'b100);
        end
      end
      @(negedge clk);
      if (!rst) return;
      check($sformatf("i%0d frame end {ser,act,done,rdy}", g),
            32'({tx_serial, tx_active, tx_done, tx_ready}), 32'b1011);
    endtask

    // Monitor: an accept is due whenever valid and ready are both seen.
    initial begin
      forever begin
        if (rst === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
          run_frame();
        end else begin
          @(negedge clk);
          if (rst === 1'b1)
            check($sformatf("i%0d idle {ser,act,done,rdy}", g),
                  32'({tx_serial, tx_active, tx_done, tx_ready}), 32'b1001);
        end
      end
    end

    // Driver
    initial begin
      #2 rst = 1'b0;
      #1;
      check($sformatf("i%0d reset values {ser,act,done,rdy}", g),
            32'({tx_serial, tx_active, tx_done, tx_ready}), 32'b1001);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;

      present(9'h0A5, 4, 1'b0); wait_accept(); idle_gap(50);
      present(9'h007, 2, 1'b1); wait_accept(); idle_gap(30);
      present(9'h007, 2, 1'b0); wait_accept(); idle_gap(30);
      present(9'h055, 1, 1'b0); wait_accept();
      present(9'h055, 1, 1'b1); wait_accept();
      present(9'h02A, 0, 1'b0); wait_accept(); idle_gap(20);
      present(9'h03C, 0, 1'b1); wait_accept(); idle_gap(20);
      reset_test();
      present(9'h099, 2, 1'b1); wait_accept(); idle_gap(40);

      for (int i = 0; i < 100; i++) begin
        present(9'($urandom), int'($urandom_range(0, 5)), 1'($urandom));
        wait_accept();
        if ($urandom_range(0, 1) == 0) idle_gap(int'($urandom_range(0, 30)));
      end
      idle_gap(150);
      check($sformatf("i%0d offers left over", g), 32'(q_data.size()), 32'd0);
      fin = 1'b1;
    end
  end

  initial begin
    int t = 0;
    while (!(g_inst[0].fin && g_inst[1].fin) && t < 80000) begin
      @(posedge clk);
      t++;
    end
    check("run complete", 32'(g_inst[0].fin && g_inst[1].fin), 32'd1);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
